pic_stream_ctrl: RTL and testbench
==================================

// Module: pic_stream_ctrl
// PURPOSE
//  Sequences the picture ROM (1-cycle read latency) and streams one IMG_W x IMG_H picture per start pulse.
//  Selects the picture by index and adds row/col and frame markers.
//  Supports valid/ready backpressure through a 2-entry output skid FIFO.
//  Sits between the picture ROM and the convolution line buffers; replaces free-running address counting.
// PARAMETERS
//  IMG_W     28  pixels per row
//  IMG_H     28  rows per picture
//  NUM_IMG   1   pictures stored back-to-back in ROM
//  ADDR_W    10  ROM address width; must hold NUM_IMG*IMG_W*IMG_H-1
//  DATA_W    16  pixel width
//  SEL_W     1   picture index width
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       synchronous active-low reset
//  start      in   1       1-cycle start request
//  img_sel    in   SEL_W   picture index, sampled with start
//  busy       out  1       high from accepted start until the done cycle (inclusive)
//  done       out  1       1-cycle pulse, frame complete
//  rom_en     out  1       ROM read strobe
//  rom_addr   out  ADDR_W  ROM address
//  rom_data   in   DATA_W  ROM data, valid 1 cycle after rom_en
//  out_valid  out  1       pixel valid
//  out_ready  in   1       downstream accept
//  out_data   out  DATA_W  pixel
//  out_sof    out  1       first pixel of frame
//  out_eol    out  1       last pixel of a row
//  out_eof    out  1       last pixel of frame
//  out_row    out  5       row of current pixel
//  out_col    out  5       column of current pixel
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, in-flight flag 0, FSM=IDLE. Reset mid-frame aborts immediately; no done pulse.
//  - FSM IDLE->RUN on start (img_sel latched, base=img_sel*IMG_W*IMG_H, issue count=0).
//    RUN->DRAIN after the last address is issued. DRAIN->DONE when the last beat handshakes.
//    DONE->IDLE after 1 cycle, with done=1 for that cycle. start outside IDLE is ignored.
//  - Issue rule: rom_en=1 iff RUN and (fifo_cnt + inflight - pop) < 2.
//    pop = out_valid&out_ready. rom_addr = base + issue_count, truncated to ADDR_W.
//  - rom_data is written into the FIFO on the cycle after rom_en, with its row/col/sof/eol/eof tags.
//    The FIFO never overflows; no pixel is dropped or duplicated under any out_ready pattern.
//  - Timing: start sampled at edge 0; rom_en/rom_addr=base after edge 1; out_valid after edge 3.
//    Throughput is 1 pixel/clk while out_ready=1.
//  - Output holds stable (data and tags) while out_valid=1 and out_ready=0.
//  - Tags: row/col count 0..IMG_H-1 / 0..IMG_W-1 in raster order; col wraps to 0 with row+1 after eol.
//    sof at (0,0), eol at col=IMG_W-1, eof at (IMG_H-1, IMG_W-1).
//  - img_sel >= NUM_IMG: start is ignored, busy stays 0.
// CONFIGURATION
//  PIC_ZERO_PAD_EN defined:
//    - Stream is (IMG_W+2)x(IMG_H+2) with a 1-pixel zero border; 900 beats for 28x28.
//    - Border beats carry data 0 and are pushed into the FIFO without rom_en, under the same FIFO-credit rule.
//    - Interior beats read ROM in raster order. row/col are padded coordinates (0..29).
//  PIC_ZERO_PAD_EN undefined: no border logic; exactly IMG_W*IMG_H beats.
// TESTING
//  - Reset, start=1 for 1 cycle, img_sel=0, out_ready=1 -> first beat 3 cycles later with data=ROM[0] and sof=1.
//    Then 784 consecutive beats, addr 0..783; eof on beat 784 at row=27, col=27; done the cycle after.
//  - out_ready toggles 1,0,0,1 repeatedly -> the sequence equals ROM[0..783] exactly.
//    At most 2 reads outstanding beyond accepted beats; outputs stable while stalled.
//  - NUM_IMG=2, img_sel=1 -> rom_addr runs 784..1567. img_sel=2 -> ignored, busy=0.
//  - start pulsed at beat 100 -> ignored; frame completes normally with one done pulse.
//  - rst_n=0 at beat 400 -> next cycle out_valid=0, busy=0, rom_en=0.
//    A new start then restarts from addr base with sof=1.
//  - PIC_ZERO_PAD_EN, out_ready=1 -> 900 beats; the first 31 beats are 0 (row 0 plus (1,0)).
//    Beat at (1,1) = ROM[0]; eof at (29,29).

Source files
------------

// File: rtl/pic_stream_ctrl.sv
// Picture ROM sequencer: streams one IMG_W x IMG_H picture per start pulse into a 2-entry skid FIFO.
// Optional 1-pixel zero border enabled by defining PIC_ZERO_PAD_EN.
module pic_stream_ctrl #(
    parameter int unsigned IMG_W   = 28,
    parameter int unsigned IMG_H   = 28,
    parameter int unsigned NUM_IMG = 1,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned SEL_W   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [SEL_W-1:0]  i_img_sel,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rom_en,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_sof,
    output logic              o_out_eol,
    output logic              o_out_eof,
    output logic [4:0]        o_out_row,
    output logic [4:0]        o_out_col
);

`ifdef PIC_ZERO_PAD_EN
    localparam int unsigned STRM_W = IMG_W + 2;
    localparam int unsigned STRM_H = IMG_H + 2;
`else
    localparam int unsigned STRM_W = IMG_W;
    localparam int unsigned STRM_H = IMG_H;
`endif
    localparam int unsigned FRAME = IMG_W * IMG_H;

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [4:0] row;
        logic [4:0] col;
        logic       sof;
        logic       eol;
        logic       eof;
        logic       pad;
    } tag_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [4:0]        row;
        logic [4:0]        col;
        logic              sof;
        logic              eol;
        logic              eof;
    } beat_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [4:0]        r_row, r_col;
    logic              r_inflight;
    tag_t              r_tag;
    beat_t             r_mem [2];
    logic              r_wptr, r_rptr;
    logic [1:0]        r_cnt;

    logic w_pop, w_credit, w_issue, w_last, w_border, w_start_ok, w_eol;

    // Credit counts FIFO entries plus the beat whose ROM data is on the bus this cycle.
    always_comb begin
        w_pop      = o_out_valid & i_out_ready;
        w_credit   = ((3'(r_cnt) + 3'(r_inflight)) - 3'(w_pop)) < 3'd2;
        w_issue    = (r_state == S_RUN) && w_credit;
        w_eol      = (r_col == 5'(STRM_W - 1));
        w_last     = (r_row == 5'(STRM_H - 1)) && w_eol;
        w_start_ok = i_start && (32'(i_img_sel) < NUM_IMG);
`ifdef PIC_ZERO_PAD_EN
        w_border   = (r_row == 5'd0) || (r_row == 5'(STRM_H - 1)) ||
                     (r_col == 5'd0) || w_eol;
`else
        w_border   = 1'b0;
`endif
    end

    assign o_rom_en    = w_issue & ~w_border;
    assign o_rom_addr  = r_addr;
    assign o_out_valid = (r_cnt != 2'd0);
    assign o_out_data  = r_mem[r_rptr].data;
    assign o_out_row   = r_mem[r_rptr].row;
    assign o_out_col   = r_mem[r_rptr].col;
    assign o_out_sof   = r_mem[r_rptr].sof;
    assign o_out_eol   = r_mem[r_rptr].eol;
    assign o_out_eof   = r_mem[r_rptr].eof;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);

    // Next-state logic; ARM gives the one-cycle start-to-first-read spacing.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next = S_ARM;
            S_ARM:   w_next = S_RUN;
            S_RUN:   if (w_issue && w_last) w_next = S_DRAIN;
            S_DRAIN: if (w_pop && o_out_eof) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_inflight <= 1'b0;
            r_tag      <= '0;
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_cnt      <= 2'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_start_ok) begin
                r_addr <= ADDR_W'(32'(i_img_sel) * FRAME);
                r_row  <= '0;
                r_col  <= '0;
            end else if (w_issue) begin
                if (!w_border) r_addr <= r_addr + ADDR_W'(1);
                if (w_eol) begin
                    r_col <= '0;
                    r_row <= r_row + 5'd1;
                end else begin
                    r_col <= r_col + 5'd1;
                end
            end

            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag.row <= r_row;
                r_tag.col <= r_col;
                r_tag.sof <= (r_row == 5'd0) && (r_col == 5'd0);
                r_tag.eol <= w_eol;
                r_tag.eof <= w_last;
                r_tag.pad <= w_border;
            end

            // Tagged beat enters the FIFO the cycle its ROM data is valid.
            if (r_inflight) begin
                r_mem[r_wptr].data <= r_tag.pad ? '0 : i_rom_data;
                r_mem[r_wptr].row  <= r_tag.row;
                r_mem[r_wptr].col  <= r_tag.col;
                r_mem[r_wptr].sof  <= r_tag.sof;
                r_mem[r_wptr].eol  <= r_tag.eol;
                r_mem[r_wptr].eof  <= r_tag.eof;
                r_wptr             <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_cnt <= (r_cnt + 2'(r_inflight)) - 2'(w_pop);
        end
    end

endmodule

// File: tb/tb_pic_stream_ctrl.sv
// Self-checking bench for pic_stream_ctrl: ROM model, raster-order stream model, directed scenarios.
module tb_pic_stream_ctrl;

    localparam int IMG_W   = 28;
    localparam int IMG_H   = 28;
    localparam int NUM_IMG = 2;
    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 16;
    localparam int SEL_W   = 2;
`ifdef PIC_ZERO_PAD_EN
    localparam int SW = IMG_W + 2;
    localparam int SH = IMG_H + 2;
`else
    localparam int SW = IMG_W;
    localparam int SH = IMG_H;
`endif
    localparam int BEATS = SW * SH;

    logic              clk, rst_n, start, rom_en, busy, done;
    logic [SEL_W-1:0]  img_sel;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data, out_data;
    logic              out_valid, out_ready, out_sof, out_eol, out_eof;
    logic [4:0]        out_row, out_col;

    int n_vec = 0;
    int n_err = 0;

    pic_stream_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_IMG(NUM_IMG),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_img_sel(img_sel),
        .o_busy(busy), .o_done(done), .o_rom_en(rom_en), .o_rom_addr(rom_addr),
        .i_rom_data(rom_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_data(out_data), .o_out_sof(out_sof), .o_out_eol(out_eol),
        .o_out_eof(out_eof), .o_out_row(out_row), .o_out_col(out_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom_f(input int a);
        return 16'(a * 37 + 32'h1234);
    endfunction

    // Picture ROM with one-cycle read latency.
    always @(posedge clk) if (rom_en) rom_data <= rom_f(int'(rom_addr));

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model state
    bit m_busy = 0, m_eof_prev = 0, m_stall = 0, m_prev_rst = 0;
    int m_base = 0, m_idx = 0, m_rd = 0, done_cnt = 0;
    logic [31:0] m_snap;

    always @(negedge clk) begin
        int k, r, c, e_data;
        bit pop, done_now;
        if (!rst_n) begin
            m_busy = 0; m_eof_prev = 0; m_stall = 0; m_prev_rst = 1;
        end else begin
            if (m_prev_rst) chk("post_reset_valid", int'(out_valid), 0);
            m_prev_rst = 0;
            chk("done", int'(done), int'(m_eof_prev));
            chk("busy", int'(busy), int'(m_busy));
            if (done) begin
                done_cnt++;
                chk("beats_per_frame", m_idx, BEATS);
            end
            if (!m_busy) begin
                chk("idle_valid", int'(out_valid), 0);
                chk("idle_rom_en", int'(rom_en), 0);
            end
            if (m_stall)
                chk("hold", int'({1'b0, out_valid, out_data, out_row, out_col,
                                  out_sof, out_eol, out_eof}), int'(m_snap));
            pop = out_valid && out_ready;
            if (rom_en) begin
                chk("rom_addr", int'(rom_addr), m_base + m_rd);
                m_rd++;
                chk("outstanding_le2", int'((m_rd - (m_idx + int'(pop))) <= 2), 1);
            end
            done_now = m_eof_prev;
            m_eof_prev = 0;
            if (pop) begin
                k = m_idx;
                r = k / SW;
                c = k % SW;
`ifdef PIC_ZERO_PAD_EN
                if (r == 0 || r == SH - 1 || c == 0 || c == SW - 1) e_data = 0;
                else e_data = int'(rom_f(m_base + (r - 1) * IMG_W + (c - 1)));
`else
                e_data = int'(rom_f(m_base + k));
`endif
                chk("data", int'(out_data), e_data);
                chk("row", int'(out_row), r);
                chk("col", int'(out_col), c);
                chk("sof_eol_eof", int'({out_sof, out_eol, out_eof}),
                    int'({k == 0, c == SW - 1, k == BEATS - 1}));
                m_eof_prev = (k == BEATS - 1);
                m_idx++;
            end
            m_stall = out_valid && !out_ready;
            m_snap  = {1'b0, out_valid, out_data, out_row, out_col, out_sof, out_eol, out_eof};
            if (done_now) m_busy = 0;
            else if (!m_busy && start && int'(img_sel) < NUM_IMG) begin
                m_busy = 1;
                m_base = int'(img_sel) * IMG_W * IMG_H;
                m_idx  = 0;
                m_rd   = 0;
            end
        end
    end

    int ready_mode = 0;
    int pat_i = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        pat_i++;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            tick();
            cycles++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_beat(input int n, input int budget);
        int c;
        c = 0;
        while (m_idx < n && c < budget) begin
            tick();
            c++;
        end
        if (m_idx < n) chk("beat_timeout", m_idx, n);
    endtask

    task automatic pulse_start(input int sel);
        img_sel = SEL_W'(sel);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int cyc, d0;
        rst_n = 1'b0; start = 1'b0; img_sel = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rom_en", int'(rom_en), 0);
        chk("rst_outs", int'({out_data, out_row, out_col, out_sof, out_eol, out_eof}), 0);
        rst_n = 1'b1;
        tick();

        // Frame 0, full throughput, pinned latency
        ready_mode = 0;
        pulse_start(0);
        chk("lat_busy_e0", int'(busy), 1);
        tick();
`ifdef PIC_ZERO_PAD_EN
        chk("lat_rom_en_e1", int'(rom_en), 0);
`else
        chk("lat_rom_en_e1", int'(rom_en), 1);
        chk("lat_addr_e1", int'(rom_addr), 0);
`endif
        tick();
        chk("lat_valid_e2", int'(out_valid), 0);
        tick();
        chk("lat_valid_e3", int'(out_valid), 1);
        chk("lat_sof_e3", int'(out_sof), 1);
`ifdef PIC_ZERO_PAD_EN
        chk("lat_data_e3", int'(out_data), 0);
`else
        chk("lat_data_e3", int'(out_data), 16'h1234);
`endif
        wait_done(4000, cyc);
        chk("throughput_cycles", cyc, BEATS);
        tick();
        chk("done_one_cycle", int'(done), 0);
        chk("idle_after_done", int'(busy), 0);

        // Frame 1 with ready pattern 1,0,0,1
        ready_mode = 1;
        pulse_start(1);
        wait_done(8000, cyc);
        tick();

        // Out-of-range picture indices are ignored
        ready_mode = 0;
        pulse_start(2);
        tick(); tick();
        chk("sel2_busy", int'(busy), 0);
        chk("sel2_rom_en", int'(rom_en), 0);
        pulse_start(3);
        tick();
        chk("sel3_busy", int'(busy), 0);

        // Start mid-frame is ignored; random backpressure
        ready_mode = 2;
        d0 = done_cnt;
        pulse_start(0);
        wait_beat(100, 4000);
        pulse_start(1);
        wait_done(8000, cyc);
        tick(); tick();
        chk("one_done_pulse", done_cnt - d0, 1);

        // Reset mid-frame aborts, then restart from base
        ready_mode = 0;
        pulse_start(0);
        wait_beat(400, 4000);
        d0 = done_cnt;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rom_en", int'(rom_en), 0);
        tick(); tick(); tick();
        chk("abort_no_done", done_cnt - d0, 0);
        pulse_start(0);
        tick(); tick(); tick();
        chk("restart_valid", int'(out_valid), 1);
        chk("restart_sof", int'(out_sof), 1);
        wait_done(4000, cyc);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
